multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the add/lw/sw datapath. It replaces the single-cycle decoder with an FSM that runs each instruction through fetch, decode, execute, memory and writeback. Instruction and data memory accesses share one port with a req/ready handshake. It drives the same datapath controls (RegDst, RegWrite, ALUSrc, ALUcontrol, MemToReg) plus PC, IR and memory-port controls. It counts retired instructions and halts on a memory timeout.

---
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the add/lw/sw datapath: fetch, decode, execute, memory and writeback
// over one shared memory port, with a retired-instruction counter and a memory-timeout halt.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             pc_write,
   output logic             ir_write,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic             MemToReg,
   output logic [3:0]       ALUcontrol,
   output logic [2:0]       state,
   output logic             illegal,
   output logic             fault,
   output logic [CNT_W-1:0] instr_count
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [5:0]  OP_ADD  = 6'b000001;
   localparam logic [5:0]  OP_SW   = 6'b000010;
   localparam logic [5:0]  OP_LW   = 6'b000100;
   localparam logic [3:0]  ALU_ADD = 4'b0101;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC_R = 3'd2,
      WB_R   = 3'd3,
      ADDR   = 3'd4,
      MEM    = 3'd5,
      WB_M   = 3'd6,
      HALT   = 3'd7
   } state_e;

   state_e            state_q, state_d;
   logic [5:0]        op_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic              fetch_pend_q;
   logic              mem_we_q, iord_q, reg_dst_q, reg_write_q, alu_src_q, mem_to_reg_q;
   logic [3:0]        alu_ctrl_q;
   logic              illegal_q, fault_q;
   logic [CNT_W-1:0]  instr_count_q;

   logic mem_req_c, mem_wait_c, timeout_c, legal_c, retire_c;

   // Reset gates the request so an access in flight is dropped as soon as rst_n falls.
   assign mem_req_c  = rst_n && (((state_q == FETCH) && (run || fetch_pend_q)) || (state_q == MEM));
   assign mem_wait_c = mem_req_c && !mem_ready;
   assign timeout_c  = (MEM_TIMEOUT != 0) && mem_wait_c &&
                       (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
   assign legal_c    = (opcode == OP_ADD) || (opcode == OP_SW) || (opcode == OP_LW);
   assign retire_c   = (state_q == WB_R) || (state_q == WB_M) ||
                       ((state_q == MEM) && mem_ready && (op_q == OP_SW));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH: begin
            if (mem_req_c && mem_ready) state_d = DECODE;
            else if (timeout_c)         state_d = HALT;
         end
         DECODE: begin
            if (opcode == OP_ADD)                         state_d = EXEC_R;
            else if ((opcode == OP_SW) || (opcode == OP_LW)) state_d = ADDR;
            else                                          state_d = FETCH;
         end
         EXEC_R: state_d = WB_R;
         WB_R:   state_d = FETCH;
         ADDR:   state_d = MEM;
         MEM: begin
            if (mem_ready)      state_d = (op_q == OP_SW) ? FETCH : WB_M;
            else if (timeout_c) state_d = HALT;
         end
         WB_M:   state_d = FETCH;
         HALT:   state_d = HALT;
      endcase
   end

   // Datapath controls are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         op_q          <= '0;
         wait_cnt_q    <= '0;
         fetch_pend_q  <= 1'b0;
         mem_we_q      <= 1'b0;
         iord_q        <= 1'b0;
         reg_dst_q     <= 1'b0;
         reg_write_q   <= 1'b0;
         alu_src_q     <= 1'b0;
         mem_to_reg_q  <= 1'b0;
         alu_ctrl_q    <= '0;
         illegal_q     <= 1'b0;
         fault_q       <= 1'b0;
         instr_count_q <= '0;
      end else begin
         state_q      <= state_d;
         if (state_q == DECODE) op_q <= opcode;
         wait_cnt_q   <= mem_wait_c ? wait_cnt_q + WAIT_W'(1) : '0;
         fetch_pend_q <= (state_d == FETCH) && mem_wait_c;
         mem_we_q     <= (state_d == MEM) && (op_q == OP_SW);
         iord_q       <= (state_d == MEM);
         reg_dst_q    <= (state_d == WB_R);
         reg_write_q  <= (state_d == WB_R) || (state_d == WB_M);
         alu_src_q    <= (state_d == ADDR) || (state_d == MEM);
         mem_to_reg_q <= (state_d == WB_M);
         alu_ctrl_q   <= ((state_d == EXEC_R) || (state_d == ADDR) || (state_d == MEM)) ?
                         ALU_ADD : 4'b0000;
         illegal_q    <= (state_q == DECODE) && !legal_c;
         fault_q      <= fault_q || (state_d == HALT);
         if (retire_c) instr_count_q <= instr_count_q + CNT_W'(1);
      end
   end

   assign mem_req     = mem_req_c;
   assign pc_write    = (state_q == FETCH) && mem_req_c && mem_ready;
   assign ir_write    = (state_q == FETCH) && mem_req_c && mem_ready;
   assign mem_we      = mem_we_q;
   assign iord        = iord_q;
   assign RegDst      = reg_dst_q;
   assign RegWrite    = reg_write_q;
   assign ALUSrc      = alu_src_q;
   assign MemToReg    = mem_to_reg_q;
   assign ALUcontrol  = alu_ctrl_q;
   assign state       = state_q;
   assign illegal     = illegal_q;
   assign fault       = fault_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle traces built from the
// instruction-level timing rules, with randomized opcodes, wait states and ignored inputs.
module tb_multicycle_ctrl;

   localparam int unsigned TMO = 4;
   localparam int unsigned CW  = 4;
   localparam logic [5:0] OP_ADD = 6'b000001;
   localparam logic [5:0] OP_SW  = 6'b000010;
   localparam logic [5:0] OP_LW  = 6'b000100;
   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC_R = 3'd2, S_WB_R = 3'd3;
   localparam logic [2:0] S_ADDR = 3'd4, S_MEM = 3'd5, S_WB_M = 3'd6, S_HALT = 3'd7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          run = 1'b0;
   logic          mem_ready = 1'b0;
   logic [5:0]    opcode = '0;
   logic          mem_req, mem_we, iord, pc_write, ir_write;
   logic          RegDst, RegWrite, ALUSrc, MemToReg, illegal, fault;
   logic [3:0]    ALUcontrol;
   logic [2:0]    state;
   logic [CW-1:0] instr_count;

   int            n_checks = 0;
   int            n_pass = 0;
   logic [CW-1:0] exp_cnt = '0;
   bit            pend_illegal = 1'b0;
   logic [9:0]    act_ctl;

   multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .pc_write(pc_write),
      .ir_write(ir_write), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
      .MemToReg(MemToReg), .ALUcontrol(ALUcontrol), .state(state), .illegal(illegal),
      .fault(fault), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   assign act_ctl = {mem_we, iord, RegDst, RegWrite, ALUSrc, MemToReg, ALUcontrol};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Expected {mem_we, iord, RegDst, RegWrite, ALUSrc, MemToReg, ALUcontrol} for each step.
   function automatic logic [9:0] exp_ctl(input logic [2:0] s, input logic [5:0] op);
      case (s)
         S_EXEC_R: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101};
         S_WB_R:   return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
         S_ADDR:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101};
         S_MEM:    return {op == OP_SW, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101};
         S_WB_M:   return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
         default:  return 10'b0;
      endcase
   endfunction

   task automatic do_reset();
      run = 1'b0; mem_ready = 1'b0; rst_n = 1'b0;
      #2;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      exp_cnt = '0; pend_illegal = 1'b0;
   endtask

   // One instruction: wf/wm wait cycles on the fetch/data access (>= TMO means it never completes).
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input string tag);
      logic [2:0] st[$];
      logic       rd[$];
      bit         legal, halted, decoded;
      int         dec_idx;
      legal   = (op == OP_ADD) || (op == OP_SW) || (op == OP_LW);
      halted  = 1'b0; decoded = 1'b0; dec_idx = -1;
      for (int i = 0; i < wf && i < TMO; i++) begin st.push_back(S_FETCH); rd.push_back(1'b0); end
      if (wf >= TMO) halted = 1'b1;
      else begin
         st.push_back(S_FETCH); rd.push_back(1'b1);
         dec_idx = st.size();
         st.push_back(S_DECODE); rd.push_back(1'($urandom_range(1)));
         decoded = 1'b1;
         if (op == OP_ADD) begin
            st.push_back(S_EXEC_R); rd.push_back(1'($urandom_range(1)));
            st.push_back(S_WB_R);   rd.push_back(1'($urandom_range(1)));
         end else if (legal) begin
            st.push_back(S_ADDR); rd.push_back(1'($urandom_range(1)));
            for (int i = 0; i < wm && i < TMO; i++) begin st.push_back(S_MEM); rd.push_back(1'b0); end
            if (wm >= TMO) halted = 1'b1;
            else begin
               st.push_back(S_MEM); rd.push_back(1'b1);
               if (op == OP_LW) begin st.push_back(S_WB_M); rd.push_back(1'($urandom_range(1))); end
            end
         end
      end
      if (halted) begin st.push_back(S_HALT); rd.push_back(1'($urandom_range(1))); end
      run = 1'b1;
      for (int i = 0; i < st.size(); i++) begin
         logic [2:0] es;
         logic       ereq, estb, eill;
         es        = st[i];
         mem_ready = rd[i];
         opcode    = (i == dec_idx) ? op : 6'($urandom);
         ereq      = (es == S_FETCH) || (es == S_MEM);
         estb      = (es == S_FETCH) && rd[i];
         eill      = (i == 0) && pend_illegal;
         @(negedge clk);
         n_checks++; if (state !== es) $display("FAIL %s[%0d] state: got %0d want %0d", tag, i, state, es); else n_pass++;
         n_checks++; if (act_ctl !== exp_ctl(es, op)) $display("FAIL %s[%0d] controls: got %b want %b", tag, i, act_ctl, exp_ctl(es, op)); else n_pass++;
         n_checks++; if (mem_req !== ereq) $display("FAIL %s[%0d] mem_req: got %b want %b", tag, i, mem_req, ereq); else n_pass++;
         n_checks++; if ({pc_write, ir_write} !== {estb, estb}) $display("FAIL %s[%0d] pc/ir_write: got %b%b want %b", tag, i, pc_write, ir_write, estb); else n_pass++;
         n_checks++; if (illegal !== eill) $display("FAIL %s[%0d] illegal: got %b want %b", tag, i, illegal, eill); else n_pass++;
         n_checks++; if (fault !== (es == S_HALT)) $display("FAIL %s[%0d] fault: got %b want %b", tag, i, fault, es == S_HALT); else n_pass++;
         n_checks++; if (instr_count !== exp_cnt) $display("FAIL %s[%0d] instr_count: got %0d want %0d", tag, i, instr_count, exp_cnt); else n_pass++;
         @(posedge clk); #1;
      end
      if (decoded && legal && !halted) exp_cnt = exp_cnt + CW'(1);
      pend_illegal = decoded && !legal;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = OP_ADD;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (state !== S_FETCH) $display("FAIL reset state: got %0d want 0", state); else n_pass++;
      n_checks++; if ({mem_req, pc_write, ir_write} !== 3'b000) $display("FAIL reset strobes: got %b want 000", {mem_req, pc_write, ir_write}); else n_pass++;
      n_checks++; if (act_ctl !== 10'b0) $display("FAIL reset controls: got %b want 0", act_ctl); else n_pass++;
      n_checks++; if ({illegal, fault, instr_count} !== '0) $display("FAIL reset status: got %b/%b/%0d want 0", illegal, fault, instr_count); else n_pass++;
      run = 1'b0; mem_ready = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(negedge clk);
      n_checks++; if ({state, mem_req, pc_write} !== 5'b000_00) $display("FAIL idle_run0: got st=%0d req=%b pcw=%b want 0/0/0", state, mem_req, pc_write); else n_pass++;
      @(posedge clk); #1;
      mem_ready = 1'b0; exp_cnt = '0; pend_illegal = 1'b0;
   endtask

   task automatic test_add();     run_instr(OP_ADD, 0, 0, "add");     endtask
   task automatic test_lw_wait(); run_instr(OP_LW, 0, 3, "lw_wait3"); endtask
   task automatic test_sw();      run_instr(OP_SW, 0, 0, "sw");       endtask

   task automatic test_illegal();
      run_instr(6'b111111, 0, 0, "illegal");
      run_instr(OP_ADD, 1, 0, "after_illegal");
   endtask

   task automatic test_random();
      logic [5:0] bad[5];
      bad = '{6'h00, 6'h03, 6'h3f, 6'h08, 6'h05};
      for (int k = 0; k < 40; k++) begin
         logic [5:0] op;
         int unsigned r;
         r = $urandom_range(9);
         op = (r < 3) ? OP_ADD : (r < 6) ? OP_LW : (r < 9) ? OP_SW : bad[$urandom_range(4)];
         run_instr(op, int'($urandom_range(TMO - 1)), int'($urandom_range(TMO - 1)), "random");
      end
   endtask

   task automatic test_timeout();
      run_instr(OP_ADD, TMO, 0, "tmo_fetch");
      repeat (3) begin
         mem_ready = 1'($urandom_range(1)); run = 1'b1;
         @(negedge clk);
         n_checks++; if ({state, fault, mem_req, pc_write} !== {S_HALT, 3'b100}) $display("FAIL halt_hold: got st=%0d fault=%b req=%b pcw=%b want 7/1/0/0", state, fault, mem_req, pc_write); else n_pass++;
         @(posedge clk); #1;
      end
      do_reset();
      n_checks++; if ({state, fault} !== 4'b0000) $display("FAIL halt_reset: got st=%0d fault=%b want 0/0", state, fault); else n_pass++;
      run_instr(OP_ADD, TMO - 1, 0, "tmo_edge_fetch");
      run_instr(OP_LW, 0, TMO - 1, "tmo_edge_mem");
      run_instr(OP_SW, 0, TMO, "tmo_mem");
      do_reset();
   endtask

   task automatic test_run_deassert();
      do_reset();
      run = 1'b1; mem_ready = 1'b0; opcode = 6'($urandom);
      @(negedge clk);
      n_checks++; if (mem_req !== 1'b1) $display("FAIL rd_first_req: got %b want 1", mem_req); else n_pass++;
      @(posedge clk); #1;
      run = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_checks++; if ({state, mem_req} !== {S_FETCH, 1'b1}) $display("FAIL rd_hold_req: got st=%0d req=%b want 0/1", state, mem_req); else n_pass++;
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      @(negedge clk);
      n_checks++; if ({pc_write, ir_write} !== 2'b11) $display("FAIL rd_ready: got %b%b want 11", pc_write, ir_write); else n_pass++;
      @(posedge clk); #1;
      opcode = OP_ADD; mem_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (state !== S_DECODE) $display("FAIL rd_decode: got %0d want 1", state); else n_pass++;
      @(posedge clk); #1;
      opcode = 6'($urandom);
      repeat (2) @(posedge clk);
      #1;
      exp_cnt = exp_cnt + CW'(1);
      repeat (3) begin
         mem_ready = 1'($urandom_range(1));
         @(negedge clk);
         n_checks++; if ({state, mem_req, pc_write} !== 5'b000_00) $display("FAIL rd_idle: got st=%0d req=%b pcw=%b want 0/0/0", state, mem_req, pc_write); else n_pass++;
         n_checks++; if (instr_count !== exp_cnt) $display("FAIL rd_count: got %0d want %0d", instr_count, exp_cnt); else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      run = 1'b1; mem_ready = 1'b1;
      @(posedge clk); #1;
      opcode = OP_SW; mem_ready = 1'b0;
      @(posedge clk); #1;
      run = 1'b0; opcode = 6'($urandom);
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if ({state, mem_req, mem_we, iord} !== {S_MEM, 3'b111}) $display("FAIL mid_mem_pre: got st=%0d req=%b we=%b iord=%b want 5/1/1/1", state, mem_req, mem_we, iord); else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if ({state, mem_req, pc_write, ir_write} !== 6'b000_000) $display("FAIL mid_mem_reset strobes: got st=%0d req=%b pcw=%b irw=%b want 0", state, mem_req, pc_write, ir_write); else n_pass++;
      n_checks++; if (act_ctl !== 10'b0) $display("FAIL mid_mem_reset controls: got %b want 0", act_ctl); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      exp_cnt = '0; pend_illegal = 1'b0;
   endtask

   task automatic test_back_to_back_wrap();
      do_reset();
      for (int k = 0; k < 17; k++) run_instr(OP_ADD, 0, 0, "wrap");
      @(negedge clk);
      n_checks++; if (instr_count !== CW'(1)) $display("FAIL wrap_count: got %0d want 1", instr_count); else n_pass++;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_sw();
      test_illegal();
      test_random();
      test_timeout();
      test_run_deassert();
      test_reset_mid_mem();
      test_back_to_back_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
